// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS fetch stage: reset/trap vectors,
// the NOP encoding, the kernel-bit index and the next-PC source encoding.
package mips_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
   localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam int unsigned KBIT         = 31;

   typedef enum logic [2:0] {
      SEL_SEQ   = 3'd0,
      SEL_IRQ   = 3'd1,
      SEL_HOLD  = 3'd2,
      SEL_REDIR = 3'd3,
      SEL_EXC   = 3'd4
   } pc_sel_e;

   // The mode bit rides along unchanged; only the 31-bit address wraps.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return {pc[KBIT], pc[30:0] + 31'd4};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM port, decode-side control inputs and the IF/ID outputs.
interface if_stage_if;
   logic [30:0] rom_addr;
   logic [31:0] rom_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        irq;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_trap;

   modport master (
      output rom_addr, ifid_valid, ifid_instr, ifid_pc_plus4, ifid_trap,
      input  rom_data, stall, redirect_valid, redirect_pc, exc_req, irq
   );

   modport slave (
      input  rom_addr, ifid_valid, ifid_instr, ifid_pc_plus4, ifid_trap,
      output rom_data, stall, redirect_valid, redirect_pc, exc_req, irq
   );
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC priority mux: exception > redirect > stall > interrupt > sequential,
// with kernel-bit masking on redirects and the matching IF/ID load controls.
module pc_next_sel
   import mips_pkg::*;
#(
   parameter logic [31:0] IRQ_VEC = IRQ_VECTOR,
   parameter logic [31:0] EXC_VEC = EXC_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        exc_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic        irq,
   output logic [31:0] next_pc,
   output logic [31:0] seq_pc,
   output logic        ifid_load,
   output logic        ifid_valid,
   output logic        ifid_use_rom,
   output logic        ifid_trap
);

   pc_sel_e     sel_s;
   logic [31:0] redir_tgt_s;

   // A redirect may drop into user mode but can never raise the kernel bit.
   assign redir_tgt_s = {pc[KBIT] & redirect_pc[KBIT], redirect_pc[30:0] & 31'h7FFF_FFFC};
   assign seq_pc      = pc_plus4(pc);

   // Source selection in priority order.
   always_comb begin
      sel_s = SEL_SEQ;
      if (exc_req) begin
         sel_s = SEL_EXC;
      end else if (redirect_valid) begin
         sel_s = SEL_REDIR;
      end else if (stall) begin
         sel_s = SEL_HOLD;
      end else if (irq && !pc[KBIT]) begin
         sel_s = SEL_IRQ;
      end else begin
         sel_s = SEL_SEQ;
      end
   end

   // Decode the selected source into next PC and IF/ID controls.
   always_comb begin
      next_pc      = pc;
      ifid_load    = 1'b0;
      ifid_valid   = 1'b0;
      ifid_use_rom = 1'b0;
      ifid_trap    = 1'b0;
      case (sel_s)
         SEL_EXC: begin
            next_pc   = EXC_VEC;
            ifid_load = 1'b1;
         end
         SEL_REDIR: begin
            next_pc   = redir_tgt_s;
            ifid_load = 1'b1;
         end
         SEL_HOLD: begin
            next_pc   = pc;
         end
         SEL_IRQ: begin
            next_pc    = IRQ_VEC;
            ifid_load  = 1'b1;
            ifid_valid = 1'b1;
            ifid_trap  = 1'b1;
         end
         SEL_SEQ: begin
            next_pc      = seq_pc;
            ifid_load    = 1'b1;
            ifid_valid   = 1'b1;
            ifid_use_rom = 1'b1;
         end
         default: begin
            next_pc   = pc;
            ifid_load = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM address drive and IF/ID register.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
   parameter logic [31:0] IRQ_VECTOR   = mips_pkg::IRQ_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = mips_pkg::EXC_VECTOR
) (
   input  logic       clk,
   input  logic       reset_n,
   if_stage_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic        ifid_trap_q, ifid_trap_d;

   logic [31:0] next_pc_s;
   logic [31:0] seq_pc_s;
   logic        ld_s, valid_s, use_rom_s, trap_s;

   pc_next_sel #(
      .IRQ_VEC (IRQ_VECTOR),
      .EXC_VEC (EXC_VECTOR)
   ) u_sel (
      .pc             (pc_q),
      .exc_req        (bus.exc_req),
      .redirect_valid (bus.redirect_valid),
      .redirect_pc    (bus.redirect_pc),
      .stall          (bus.stall),
      .irq            (bus.irq),
      .next_pc        (next_pc_s),
      .seq_pc         (seq_pc_s),
      .ifid_load      (ld_s),
      .ifid_valid     (valid_s),
      .ifid_use_rom   (use_rom_s),
      .ifid_trap      (trap_s)
   );

   // Next-state for PC and IF/ID; bubbles and trap slots carry a NOP.
   always_comb begin
      pc_d            = next_pc_s;
      ifid_valid_d    = ifid_valid_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_trap_d     = ifid_trap_q;
      if (ld_s) begin
         ifid_valid_d    = valid_s;
         ifid_instr_d    = use_rom_s ? bus.rom_data : NOP_INSTR;
         ifid_pc_plus4_d = seq_pc_s;
         ifid_trap_d     = trap_s;
      end else begin
         ifid_valid_d    = ifid_valid_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q            <= RESET_VECTOR;
         ifid_valid_q    <= 1'b0;
         ifid_instr_q    <= 32'h0000_0000;
         ifid_pc_plus4_q <= 32'h0000_0000;
         ifid_trap_q     <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_trap_q     <= ifid_trap_d;
      end
   end

   assign bus.rom_addr      = pc_q[30:0];
   assign bus.ifid_valid    = ifid_valid_q;
   assign bus.ifid_instr    = ifid_instr_q;
   assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
   assign bus.ifid_trap     = ifid_trap_q;

endmodule
